imem_boot_loader: RTL and testbench

- Fills instruction memory from a byte stream before the core runs.
- Owns the processor reset: holds the core's active-low reset asserted until the program image is fully written, then releases it.
- Writes instruction memory through a dedicated write port, the counterpart to the core's read-only instruction fetch path.
- Stream format: 4-byte big-endian word count N, then N instruction words, each big-endian (MSB byte first).

---
 rtl/imem_boot_loader.sv | 118 +++++++++++
 tb/tb_imem_boot_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a big-endian length-prefixed byte stream, writes it into
// instruction memory, and releases the core's reset once the image is complete.
module imem_boot_loader #(
    parameter int          IMEM_DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES   = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_rst_n,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] DEPTH_W   = 32'(IMEM_DEPTH_WORDS);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

    state_t      state_reg;
    logic [1:0]  byte_idx_reg;
    logic [23:0] shift_reg;
    logic [31:0] word_count_reg;
    logic [31:0] idle_cnt_reg;

    logic        accept;
    logic [31:0] assembled;
    logic [31:0] idle_next;
    logic        idle_active;
    logic        last_word;
    logic [31:0] word_addr;

    assign accept      = in_valid && in_ready;
    assign assembled   = {shift_reg, in_data};
    assign idle_next   = idle_cnt_reg + 32'd1;
    assign idle_active = ((state_reg == HDR) && (byte_idx_reg != 2'd0)) || (state_reg == DATA);
    assign last_word   = ({16'h0000, words_loaded} + 32'd1) == word_count_reg;
    // No wrap: the header check guarantees k < IMEM_DEPTH_WORDS.
    assign word_addr   = BASE_ADDR + {14'h0000, words_loaded, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= HDR;
            byte_idx_reg   <= 2'd0;
            shift_reg      <= 24'h0;
            word_count_reg <= 32'h0;
            idle_cnt_reg   <= 32'h0;
            in_ready       <= 1'b0;
            imem_wr_en     <= 1'b0;
            imem_wr_addr   <= BASE_ADDR;
            imem_wr_data   <= 32'h0;
            cpu_rst_n      <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            words_loaded   <= 16'h0;
        end else begin
            imem_wr_en <= 1'b0;
            unique case (state_reg)
                HDR, DATA: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        idle_cnt_reg <= 32'h0;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        shift_reg    <= assembled[23:0];
                        if (byte_idx_reg == 2'd3) begin
                            if (state_reg == HDR) begin
                                word_count_reg <= assembled;
                                if (assembled == 32'h0) begin
                                    state_reg <= DONE;
                                    in_ready  <= 1'b0;
                                    load_done <= 1'b1;
                                    cpu_rst_n <= 1'b1;
                                end else if (assembled > DEPTH_W) begin
                                    state_reg <= ERR;
                                    in_ready  <= 1'b0;
                                    load_err  <= 1'b1;
                                end else begin
                                    state_reg <= DATA;
                                end
                            end else begin
                                imem_wr_en   <= 1'b1;
                                imem_wr_data <= assembled;
                                imem_wr_addr <= word_addr;
                                words_loaded <= words_loaded + 16'd1;
                                // Final write and reset release land together.
                                if (last_word) begin
                                    state_reg <= DONE;
                                    in_ready  <= 1'b0;
                                    load_done <= 1'b1;
                                    cpu_rst_n <= 1'b1;
                                end
                            end
                        end
                    end else if (idle_active) begin
                        if (idle_next >= TIMEOUT_W) begin
                            state_reg <= ERR;
                            in_ready  <= 1'b0;
                            load_err  <= 1'b1;
                        end else begin
                            idle_cnt_reg <= idle_next;
                        end
                    end
                end
                DONE: in_ready <= 1'b0;
                ERR:  in_ready <= 1'b0;
                default: state_reg <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: one instance at BASE 0 with a short timeout,
// one at BASE 0x100 with a 4-word memory.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, vld_a, rdy_a, wen_a, crst_a, done_a, err_a;
    logic [7:0]  dat_a;
    logic [31:0] waddr_a, wdata_a;
    logic [15:0] wl_a;
    logic        rst_n_b, vld_b, rdy_b, wen_b, crst_b, done_b, err_b;
    logic [7:0]  dat_b;
    logic [31:0] waddr_b, wdata_b;
    logic [15:0] wl_b;

    imem_boot_loader #(.IMEM_DEPTH_WORDS(256), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(16)) u_a (
        .clk(clk), .rst_n(rst_n_a), .in_valid(vld_a), .in_data(dat_a), .in_ready(rdy_a),
        .imem_wr_en(wen_a), .imem_wr_addr(waddr_a), .imem_wr_data(wdata_a),
        .cpu_rst_n(crst_a), .load_done(done_a), .load_err(err_a), .words_loaded(wl_a));

    imem_boot_loader #(.IMEM_DEPTH_WORDS(4), .BASE_ADDR(32'h100)) u_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(vld_b), .in_data(dat_b), .in_ready(rdy_b),
        .imem_wr_en(wen_b), .imem_wr_addr(waddr_b), .imem_wr_data(wdata_b),
        .cpu_rst_n(crst_b), .load_done(done_b), .load_err(err_b), .words_loaded(wl_b));

    int errors = 0;
    int checks = 0;
    logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    logic        qa_done[$], qb_done[$];

    // Write log; also records whether load_done/cpu_rst_n were high alongside each pulse.
    always @(negedge clk) begin
        if (wen_a) begin
            qa_addr.push_back(waddr_a); qa_data.push_back(wdata_a); qa_done.push_back(done_a & crst_a);
        end
        if (wen_b) begin
            qb_addr.push_back(waddr_b); qb_data.push_back(wdata_b); qb_done.push_back(done_b & crst_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic do_reset(input bit sel);
        @(negedge clk);
        if (sel) begin rst_n_b = 1'b0; vld_b = 1'b0; end
        else     begin rst_n_a = 1'b0; vld_a = 1'b0; end
        repeat (2) @(negedge clk);
        if (sel) begin qb_addr.delete(); qb_data.delete(); qb_done.delete(); end
        else     begin qa_addr.delete(); qa_data.delete(); qa_done.delete(); end
    endtask

    task automatic release_reset(input bit sel);
        if (sel) rst_n_b = 1'b1; else rst_n_a = 1'b1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            if (sel) vld_b = 1'b0; else vld_a = 1'b0;
        end
        @(negedge clk);
        if (sel) begin vld_b = 1'b1; dat_b = b; end
        else     begin vld_a = 1'b1; dat_a = b; end
        n = 0;
        while (!(sel ? rdy_b : rdy_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_ready_timeout", {31'b0, (sel ? rdy_b : rdy_a)}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input int gap);
        send_byte(sel, w[31:24], gap);
        send_byte(sel, w[23:16], 0);
        send_byte(sel, w[15:8], 0);
        send_byte(sel, w[7:0], 0);
    endtask

    task automatic go_idle(input bit sel, input int cycles);
        @(negedge clk);
        if (sel) vld_b = 1'b0; else vld_a = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    logic [31:0] t4_words [3];

    initial begin
        rst_n_a = 1'b0; vld_a = 1'b0; dat_a = 8'h00;
        rst_n_b = 1'b0; vld_b = 1'b0; dat_b = 8'h00;
        t4_words[0] = 32'h11223344; t4_words[1] = 32'hA5A55A5A; t4_words[2] = 32'hDEADBEEF;

        // Reset state
        do_reset(0);
        check("rst_in_ready", {31'b0, rdy_a}, 32'd0);
        check("rst_wr_en", {31'b0, wen_a}, 32'd0);
        check("rst_wr_addr", waddr_a, 32'h0);
        check("rst_wr_data", wdata_a, 32'h0);
        check("rst_cpu_rst_n", {31'b0, crst_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        check("rst_err", {31'b0, err_a}, 32'd0);
        check("rst_words", {16'h0, wl_a}, 32'd0);
        release_reset(0);
        @(negedge clk);
        check("rst_ready_after", {31'b0, rdy_a}, 32'd1);

        // Two-word back-to-back image
        send_word(0, 32'h00000002, 0);
        send_word(0, 32'h20080005, 0);
        send_word(0, 32'h01095020, 0);
        go_idle(0, 3);
        check("t1_nwrites", 32'(qa_addr.size()), 32'd2);
        if (qa_addr.size() == 2) begin
            check("t1_addr0", qa_addr[0], 32'h0);
            check("t1_data0", qa_data[0], 32'h20080005);
            check("t1_done_w0", {31'b0, qa_done[0]}, 32'd0);
            check("t1_addr1", qa_addr[1], 32'h4);
            check("t1_data1", qa_data[1], 32'h01095020);
            check("t1_done_w1", {31'b0, qa_done[1]}, 32'd1);
        end
        check("t1_words", {16'h0, wl_a}, 32'd2);
        check("t1_ready", {31'b0, rdy_a}, 32'd0);
        check("t1_addr_hold", waddr_a, 32'h4);
        check("t1_data_hold", wdata_a, 32'h01095020);
        vld_a = 1'b1; dat_a = 8'hFF;
        repeat (5) @(negedge clk);
        vld_a = 1'b0;
        @(negedge clk);
        check("t1_ignored_words", {16'h0, wl_a}, 32'd2);
        check("t1_ignored_writes", 32'(qa_addr.size()), 32'd2);

        // Empty image; also reset after done drops cpu_rst_n
        do_reset(0);
        check("t2_rst_cpu", {31'b0, crst_a}, 32'd0);
        check("t2_rst_done", {31'b0, done_a}, 32'd0);
        release_reset(0);
        send_word(0, 32'h00000000, 0);
        @(negedge clk);
        vld_a = 1'b0;
        check("t2_done", {31'b0, done_a}, 32'd1);
        check("t2_cpu", {31'b0, crst_a}, 32'd1);
        go_idle(0, 3);
        check("t2_nwrites", 32'(qa_addr.size()), 32'd0);

        // Oversize header
        do_reset(0);
        release_reset(0);
        send_word(0, 32'h00000101, 0);
        go_idle(0, 3);
        check("t3_err", {31'b0, err_a}, 32'd1);
        check("t3_ready", {31'b0, rdy_a}, 32'd0);
        check("t3_cpu", {31'b0, crst_a}, 32'd0);
        check("t3_done", {31'b0, done_a}, 32'd0);
        check("t3_nwrites", 32'(qa_addr.size()), 32'd0);

        // N=3 with random gaps up to 10 cycles
        do_reset(0);
        release_reset(0);
        send_word(0, 32'h00000003, int'($urandom_range(0, 3)));
        for (int w = 0; w < 3; w++) begin
            send_byte(0, t4_words[w][31:24], (w == 1) ? 10 : int'($urandom_range(0, 10)));
            send_byte(0, t4_words[w][23:16], int'($urandom_range(0, 10)));
            send_byte(0, t4_words[w][15:8],  int'($urandom_range(0, 10)));
            send_byte(0, t4_words[w][7:0],   int'($urandom_range(0, 10)));
        end
        go_idle(0, 3);
        check("t4_nwrites", 32'(qa_addr.size()), 32'd3);
        if (qa_addr.size() == 3) begin
            for (int w = 0; w < 3; w++) begin
                check($sformatf("t4_addr%0d", w), qa_addr[w], 32'(4 * w));
                check($sformatf("t4_data%0d", w), qa_data[w], t4_words[w]);
            end
        end
        check("t4_done", {31'b0, done_a}, 32'd1);
        check("t4_err", {31'b0, err_a}, 32'd0);

        // Mid-word stall past the timeout
        do_reset(0);
        release_reset(0);
        send_word(0, 32'h00000002, 0);
        send_byte(0, 8'h12, 0);
        send_byte(0, 8'h34, 0);
        go_idle(0, 9);
        check("t4b_err_early", {31'b0, err_a}, 32'd0);
        repeat (10) @(negedge clk);
        check("t4b_err", {31'b0, err_a}, 32'd1);
        check("t4b_ready", {31'b0, rdy_a}, 32'd0);
        check("t4b_cpu", {31'b0, crst_a}, 32'd0);

        // Reset mid-load, then fresh N=1 image
        do_reset(0);
        release_reset(0);
        send_word(0, 32'h00000004, 0);
        send_word(0, 32'hCAFEF00D, 0);
        send_byte(0, 8'h55, 0);
        send_byte(0, 8'h66, 0);
        do_reset(0);
        check("t5_rst_words", {16'h0, wl_a}, 32'd0);
        check("t5_rst_cpu", {31'b0, crst_a}, 32'd0);
        release_reset(0);
        send_word(0, 32'h00000001, 0);
        send_word(0, 32'hAC0A0000, 0);
        go_idle(0, 3);
        check("t5_nwrites", 32'(qa_addr.size()), 32'd1);
        if (qa_addr.size() == 1) begin
            check("t5_addr", qa_addr[0], 32'h0);
            check("t5_data", qa_data[0], 32'hAC0A0000);
        end
        check("t5_words", {16'h0, wl_a}, 32'd1);
        check("t5_done", {31'b0, done_a}, 32'd1);

        // Full-depth image at BASE_ADDR 0x100
        do_reset(1);
        check("t6_rst_addr", waddr_b, 32'h100);
        release_reset(1);
        send_word(1, 32'h00000004, 0);
        for (int w = 0; w < 4; w++) send_word(1, 32'hB0000000 + 32'(w), 0);
        go_idle(1, 3);
        check("t6_nwrites", 32'(qb_addr.size()), 32'd4);
        if (qb_addr.size() == 4) begin
            for (int w = 0; w < 4; w++) begin
                check($sformatf("t6_addr%0d", w), qb_addr[w], 32'h100 + 32'(4 * w));
                check($sformatf("t6_data%0d", w), qb_data[w], 32'hB0000000 + 32'(w));
            end
            check("t6_done_last", {31'b0, qb_done[3]}, 32'd1);
        end
        check("t6_done", {31'b0, done_b}, 32'd1);
        check("t6_err", {31'b0, err_b}, 32'd0);
        check("t6_words", {16'h0, wl_b}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
